// File: rtl/bram_2048x8.sv
// ---------------------------------------------------------------------------
// bram_2048x8 -- true dual-port 2048 x 8 synchronous RAM, single clock.
//
// Ports (n = 0, 1):
//   clk_i        clock, all state changes on the rising edge
//   rst_i        synchronous active-high reset; clears qn_o, memory untouched,
//                and no access takes place on either port while high
//   cen_i        port enable; no access when low, qn_o holds
//   an_i[10:0]   word address
//   dn_i[7:0]    write data
//   wen_i        write enable, qualified by cen_i
//   wemn_i[7:0]  per-bit write mask, 1 = write that bit
//   qn_o[7:0]    registered read data, latency 1
//
// Optional feature: define BRAM_2048X8_WRITE_FIRST_EN to make a writing
// port return the newly written word (write-first). Default is read-first.
// Cross-port reads always see the old word; on a same-address double write
// port 0 owns every bit that both masks select.
// ---------------------------------------------------------------------------
module bram_2048x8 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ce0_i,
    input  logic [10:0] a0_i,
    input  logic [7:0]  d0_i,
    input  logic        we0_i,
    input  logic [7:0]  wem0_i,
    output logic [7:0]  q0_o,
    input  logic        ce1_i,
    input  logic [10:0] a1_i,
    input  logic [7:0]  d1_i,
    input  logic        we1_i,
    input  logic [7:0]  wem1_i,
    output logic [7:0]  q1_o
);

    localparam int unsigned Depth = 2048;

`ifdef BRAM_2048X8_WRITE_FIRST_EN
    localparam bit WriteFirst = 1'b1;
`else
    localparam bit WriteFirst = 1'b0;
`endif

    // No reset and no initialisation: contents are undefined at power-up.
    logic [7:0] mem_q [Depth];

    logic       wr0, wr1;
    logic       same_wr;
    logic [7:0] old0, old1;
    logic [7:0] new0, new1;
    logic [7:0] wr_word0;
    logic [7:0] rd0, rd1;
    logic [7:0] q0_d, q0_q;
    logic [7:0] q1_d, q1_q;

    always_comb begin
        wr0 = ce0_i & we0_i & ~rst_i;
        wr1 = ce1_i & we1_i & ~rst_i;

        old0 = mem_q[a0_i];
        old1 = mem_q[a1_i];

        new0 = (old0 & ~wem0_i) | (d0_i & wem0_i);
        new1 = (old1 & ~wem1_i) | (d1_i & wem1_i);

        // Same-address double write: start from port 1's merged word so bits
        // only port 1 selects survive, then let port 0 override its own bits.
        same_wr  = wr0 & wr1 & (a0_i == a1_i);
        wr_word0 = same_wr ? ((new1 & ~wem0_i) | (d0_i & wem0_i)) : new0;

        rd0 = (WriteFirst && we0_i) ? new0 : old0;
        rd1 = (WriteFirst && we1_i) ? new1 : old1;

        q0_d = ce0_i ? rd0 : q0_q;
        q1_d = ce1_i ? rd1 : q1_q;
    end

    // Port 0 is written last so it wins a same-address collision.
    always_ff @(posedge clk_i) begin
        if (wr1) begin
            mem_q[a1_i] <= new1;
        end
        if (wr0) begin
            mem_q[a0_i] <= wr_word0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q0_q <= 8'h00;
            q1_q <= 8'h00;
        end else begin
            q0_q <= q0_d;
            q1_q <= q1_d;
        end
    end

    assign q0_o = q0_q;
    assign q1_o = q1_q;

endmodule

// File: tb/tb_bram_2048x8.sv
// ---------------------------------------------------------------------------
// tb_bram_2048x8 -- self-checking bench for bram_2048x8.
// Directed table of single-cycle vectors with hand-computed expectations,
// followed by random traffic checked against a bit-validity-aware memory
// model (bits never written are treated as unknown and not compared).
// ---------------------------------------------------------------------------
module tb_bram_2048x8;

`ifdef BRAM_2048X8_WRITE_FIRST_EN
    localparam bit WF = 1'b1;
`else
    localparam bit WF = 1'b0;
`endif

    typedef struct packed {
        logic        rst;
        logic        ce0;
        logic [10:0] a0;
        logic [7:0]  d0;
        logic        we0;
        logic [7:0]  wem0;
        logic        ce1;
        logic [10:0] a1;
        logic [7:0]  d1;
        logic        we1;
        logic [7:0]  wem1;
    } in_t;

    typedef struct packed {
        in_t        in;
        logic       chk0;
        logic [7:0] q0;
        logic       chk1;
        logic [7:0] q1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce0 = 1'b0, ce1 = 1'b0;
    logic [10:0] a0 = '0, a1 = '0;
    logic [7:0]  d0 = '0, d1 = '0;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [7:0]  wem0 = '0, wem1 = '0;
    logic [7:0]  q0, q1;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: data plus per-bit "has been written" mask.
    logic [7:0] m_data [2048];
    logic [7:0] m_val  [2048];
    logic [7:0] eq0 = '0, eq1 = '0;
    logic [7:0] vq0 = '0, vq1 = '0;

    vec_t vecs [32];
    int   n_vec = 0;

    always #5 clk = ~clk;

    bram_2048x8 dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .ce0_i  (ce0),
        .a0_i   (a0),
        .d0_i   (d0),
        .we0_i  (we0),
        .wem0_i (wem0),
        .q0_o   (q0),
        .ce1_i  (ce1),
        .a1_i   (a1),
        .d1_i   (d1),
        .we1_i  (we1),
        .wem1_i (wem1),
        .q1_o   (q1)
    );

    function automatic in_t mk(input logic r,
                               input logic c0, input logic [10:0] ad0, input logic [7:0] dd0,
                               input logic w0, input logic [7:0] m0,
                               input logic c1, input logic [10:0] ad1, input logic [7:0] dd1,
                               input logic w1, input logic [7:0] m1);
        in_t v;
        v.rst = r;
        v.ce0 = c0; v.a0 = ad0; v.d0 = dd0; v.we0 = w0; v.wem0 = m0;
        v.ce1 = c1; v.a1 = ad1; v.d1 = dd1; v.we1 = w1; v.wem1 = m1;
        return v;
    endfunction

    task automatic add(input in_t v, input logic c0, input logic [7:0] e0,
                       input logic c1, input logic [7:0] e1);
        vecs[n_vec] = '{in: v, chk0: c0, q0: e0, chk1: c1, q1: e1};
        n_vec++;
    endtask

    // Apply one edge worth of inputs, advance the model, sample #1 after.
    task automatic step(input in_t v);
        logic [7:0] o0, o1, ov0, ov1;
        rst = v.rst;
        ce0 = v.ce0; a0 = v.a0; d0 = v.d0; we0 = v.we0; wem0 = v.wem0;
        ce1 = v.ce1; a1 = v.a1; d1 = v.d1; we1 = v.we1; wem1 = v.wem1;
        if (v.rst) begin
            eq0 = 8'h00; vq0 = 8'hFF;
            eq1 = 8'h00; vq1 = 8'hFF;
        end else begin
            o0 = m_data[v.a0]; ov0 = m_val[v.a0];
            o1 = m_data[v.a1]; ov1 = m_val[v.a1];
            if (v.ce0) begin
                if (WF && v.we0) begin
                    eq0 = (o0 & ~v.wem0) | (v.d0 & v.wem0);
                    vq0 = ov0 | v.wem0;
                end else begin
                    eq0 = o0; vq0 = ov0;
                end
            end
            if (v.ce1) begin
                if (WF && v.we1) begin
                    eq1 = (o1 & ~v.wem1) | (v.d1 & v.wem1);
                    vq1 = ov1 | v.wem1;
                end else begin
                    eq1 = o1; vq1 = ov1;
                end
            end
            // Port 1 first, port 0 second: port 0 has the final say.
            if (v.ce1 && v.we1) begin
                m_data[v.a1] = (m_data[v.a1] & ~v.wem1) | (v.d1 & v.wem1);
                m_val[v.a1]  = m_val[v.a1] | v.wem1;
            end
            if (v.ce0 && v.we0) begin
                m_data[v.a0] = (m_data[v.a0] & ~v.wem0) | (v.d0 & v.wem0);
                m_val[v.a0]  = m_val[v.a0] | v.wem0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp, input logic [7:0] vmask);
        n_cmp++;
        if (((act ^ exp) & vmask) != 8'h00) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h (mask %02h) at %0t",
                     name, act, exp, vmask, $time);
        end
    endtask

    function automatic logic [10:0] pick_addr();
        int unsigned r;
        r = $urandom_range(0, 7);
        if (r < 6) return 11'(r);
        else if (r == 6) return 11'h7FF;
        else return 11'h400;
    endfunction

    function automatic logic [7:0] pick_mask();
        int unsigned r;
        r = $urandom_range(0, 5);
        if (r == 0) return 8'h00;
        else if (r < 3) return 8'hFF;
        else return 8'($urandom);
    endfunction

    initial begin
        in_t v;
        for (int i = 0; i < 2048; i++) begin
            m_data[i] = 8'h00;
            m_val[i]  = 8'h00;
        end

        //    rst ce0 a0       d0     we0 wem0   ce1 a1       d1     we1 wem1
        add(mk(1, 0, 11'h000, 8'h00, 0, 8'h00, 0, 11'h000, 8'h00, 0, 8'h00),
            1, 8'h00, 1, 8'h00);
        add(mk(0, 1, 11'h005, 8'hA5, 1, 8'hFF, 0, 11'h000, 8'h00, 0, 8'h00),
            WF, 8'hA5, 1, 8'h00);
        add(mk(0, 0, 11'h000, 8'h00, 0, 8'h00, 1, 11'h005, 8'h00, 0, 8'h00),
            0, 8'h00, 1, 8'hA5);
        add(mk(0, 1, 11'h7FF, 8'hFF, 1, 8'hFF, 0, 11'h000, 8'h00, 0, 8'h00),
            WF, 8'hFF, 1, 8'hA5);
        add(mk(0, 0, 11'h000, 8'h00, 0, 8'h00, 1, 11'h7FF, 8'h00, 1, 8'h0F),
            0, 8'h00, 1, WF ? 8'hF0 : 8'hFF);
        add(mk(0, 1, 11'h7FF, 8'h00, 0, 8'h00, 1, 11'h7FF, 8'h00, 0, 8'h00),
            1, 8'hF0, 1, 8'hF0);
        add(mk(0, 1, 11'h010, 8'h11, 1, 8'hFF, 0, 11'h000, 8'h00, 0, 8'h00),
            WF, 8'h11, 1, 8'hF0);
        add(mk(0, 1, 11'h010, 8'h22, 1, 8'hFF, 1, 11'h010, 8'h00, 0, 8'h00),
            1, WF ? 8'h22 : 8'h11, 1, 8'h11);
        add(mk(0, 1, 11'h010, 8'h00, 0, 8'h00, 1, 11'h010, 8'h00, 0, 8'h00),
            1, 8'h22, 1, 8'h22);
        add(mk(0, 1, 11'h020, 8'h3C, 1, 8'hFF, 1, 11'h020, 8'hC3, 1, 8'hFF),
            WF, 8'h3C, WF, 8'hC3);
        add(mk(0, 1, 11'h020, 8'h00, 0, 8'h00, 1, 11'h020, 8'h00, 0, 8'h00),
            1, 8'h3C, 1, 8'h3C);
        add(mk(0, 1, 11'h020, 8'h3C, 1, 8'hF0, 1, 11'h020, 8'hC3, 1, 8'hFF),
            1, 8'h3C, 1, WF ? 8'hC3 : 8'h3C);
        add(mk(0, 1, 11'h020, 8'h00, 0, 8'h00, 1, 11'h020, 8'h00, 0, 8'h00),
            1, 8'h33, 1, 8'h33);
        add(mk(0, 1, 11'h030, 8'h5A, 1, 8'hFF, 0, 11'h000, 8'h00, 0, 8'h00),
            WF, 8'h5A, 1, 8'h33);
        add(mk(0, 1, 11'h030, 8'h00, 0, 8'h00, 0, 11'h000, 8'h00, 0, 8'h00),
            1, 8'h5A, 1, 8'h33);
        // Reset with writes requested on both ports: they must be ignored.
        add(mk(1, 1, 11'h030, 8'h00, 1, 8'hFF, 1, 11'h030, 8'hFF, 1, 8'hFF),
            1, 8'h00, 1, 8'h00);
        add(mk(0, 0, 11'h030, 8'h00, 0, 8'h00, 0, 11'h030, 8'h00, 0, 8'h00),
            1, 8'h00, 1, 8'h00);
        add(mk(0, 1, 11'h030, 8'h00, 0, 8'h00, 1, 11'h030, 8'h00, 0, 8'h00),
            1, 8'h5A, 1, 8'h5A);
        add(mk(0, 1, 11'h040, 8'h11, 1, 8'hFF, 0, 11'h000, 8'h00, 0, 8'h00),
            WF, 8'h11, 1, 8'h5A);
        add(mk(0, 1, 11'h040, 8'h77, 1, 8'hFF, 0, 11'h000, 8'h00, 0, 8'h00),
            1, WF ? 8'h77 : 8'h11, 1, 8'h5A);
        // Zero mask write behaves as a plain read.
        add(mk(0, 1, 11'h040, 8'hFF, 1, 8'h00, 1, 11'h040, 8'h00, 0, 8'h00),
            1, 8'h77, 1, 8'h77);
        add(mk(0, 1, 11'h040, 8'h00, 0, 8'h00, 1, 11'h000, 8'h00, 0, 8'h00),
            1, 8'h77, 0, 8'h00);
        // 11'h000 must not alias 11'h7FF or 11'h400.
        add(mk(0, 1, 11'h000, 8'h96, 1, 8'hFF, 1, 11'h400, 8'h69, 1, 8'hFF),
            WF, 8'h96, WF, 8'h69);
        add(mk(0, 1, 11'h7FF, 8'h00, 0, 8'h00, 1, 11'h000, 8'h00, 0, 8'h00),
            1, 8'hF0, 1, 8'h96);
        add(mk(0, 1, 11'h400, 8'h00, 0, 8'h00, 0, 11'h000, 8'h00, 0, 8'h00),
            1, 8'h69, 1, 8'h96);

        for (int i = 0; i < n_vec; i++) begin
            step(vecs[i].in);
            if (vecs[i].chk0) check($sformatf("vec%0d_q0", i), q0, vecs[i].q0, 8'hFF);
            if (vecs[i].chk1) check($sformatf("vec%0d_q1", i), q1, vecs[i].q1, 8'hFF);
        end

        // Random traffic on a small address pool to force collisions.
        for (int i = 0; i < 3000; i++) begin
            v.rst  = ($urandom_range(0, 63) == 0);
            v.ce0  = ($urandom_range(0, 3) != 0);
            v.a0   = pick_addr();
            v.d0   = 8'($urandom);
            v.we0  = $urandom_range(0, 1) == 1;
            v.wem0 = pick_mask();
            v.ce1  = ($urandom_range(0, 3) != 0);
            v.a1   = pick_addr();
            v.d1   = 8'($urandom);
            v.we1  = $urandom_range(0, 1) == 1;
            v.wem1 = pick_mask();
            step(v);
            check("rand_q0", q0, eq0, vq0);
            check("rand_q1", q1, eq1, vq1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
